// File: rtl/pipeline_control_sequencer.sv
// Pipeline stall control and multi-cycle mult/div sequencer for an in-order CPU.
// Optional stall-cycle statistic counter is enabled by defining STALL_COUNTER_EN.
module pipeline_control_sequencer #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hz_load_stall,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        hilo_read,
    input  logic        md_cancel,
    output logic        pc_enable,
    output logic        if_id_enable,
    output logic        id_nop,
    output logic        md_go,
    output logic        md_sel_div,
    output logic        md_busy,
    output logic        md_finish,
    output logic [31:0] stall_cycles
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Latencies are clamped into 1..32 so the 5-bit counter load never wraps.
    localparam int MULT_N = (MULT_CYCLES < 1) ? 1 : ((MULT_CYCLES > 32) ? 32 : MULT_CYCLES);
    localparam int DIV_N  = (DIV_CYCLES  < 1) ? 1 : ((DIV_CYCLES  > 32) ? 32 : DIV_CYCLES);
    localparam logic [4:0] MULT_LOAD = 5'(MULT_N - 1);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_N - 1);

    logic [0:0] state;
    logic [4:0] cnt;
    logic       sel_div;
    logic       busy;
    logic       accept;
    logic       finish;
    logic       stall;

    assign busy   = (state == BUSY);
    assign accept = !reset && !busy && md_start && !hz_load_stall && !md_cancel;
    assign finish = !reset && busy && (cnt == 5'd0) && !md_cancel;

    // The finish cycle is still BUSY, so a reader or new op waits through it.
    assign stall = hz_load_stall || (busy && (md_start || hilo_read));

    assign pc_enable    = !stall;
    assign if_id_enable = !stall;
    assign id_nop       = stall;
    assign md_go        = accept;
    assign md_finish    = finish;
    assign md_busy      = busy;
    assign md_sel_div   = sel_div;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            sel_div <= 1'b0;
        end else if (!busy) begin
            if (accept) begin
                state   <= BUSY;
                cnt     <= md_is_div ? DIV_LOAD : MULT_LOAD;
                sel_div <= md_is_div;
            end
        end else if (md_cancel) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else if (cnt == 5'd0) begin
            state <= IDLE;
        end else begin
            cnt <= cnt - 5'd1;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_control_sequencer.sv
// Scoreboard bench for pipeline_control_sequencer: the driver queues hand-computed
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_pipeline_control_sequencer;

    logic        clk;
    logic        reset;
    logic        hz_load_stall;
    logic        md_start;
    logic        md_is_div;
    logic        hilo_read;
    logic        md_cancel;
    logic        pc_enable;
    logic        if_id_enable;
    logic        id_nop;
    logic        md_go;
    logic        md_sel_div;
    logic        md_busy;
    logic        md_finish;
    logic [31:0] stall_cycles;

    pipeline_control_sequencer #(.MULT_CYCLES(4), .DIV_CYCLES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .hz_load_stall(hz_load_stall),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .hilo_read    (hilo_read),
        .md_cancel    (md_cancel),
        .pc_enable    (pc_enable),
        .if_id_enable (if_id_enable),
        .id_nop       (id_nop),
        .md_go        (md_go),
        .md_sel_div   (md_sel_div),
        .md_busy      (md_busy),
        .md_finish    (md_finish),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input vector bits: {reset, hz_load_stall, md_start, md_is_div, hilo_read, md_cancel}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_RST  = 6'b100000;
    localparam logic [5:0] I_LS   = 6'b010000;
    localparam logic [5:0] I_MUL  = 6'b001000;
    localparam logic [5:0] I_DIV  = 6'b001100;
    localparam logic [5:0] I_HR   = 6'b000010;
    localparam logic [5:0] I_CN   = 6'b000001;

    // Expected vector bits: {pc_enable, if_id_enable, id_nop, md_go, md_sel_div, md_busy, md_finish}
    typedef struct {
        int          id;
        logic [6:0]  v;
        logic [31:0] s;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          step_id = 0;
    logic [31:0] exp_stall = 32'd0;

    task automatic step(input logic [5:0] in, input logic chk, input logic [6:0] ex);
        exp_t e;
        @(posedge clk);
        #1;
        {reset, hz_load_stall, md_start, md_is_div, hilo_read, md_cancel} = in;
        if (chk) begin
            e.id = step_id;
            e.v  = ex;
`ifdef STALL_COUNTER_EN
            e.s  = exp_stall;
`else
            e.s  = 32'd0;
`endif
            sb.push_back(e);
        end
        // Counter model: cleared by reset, otherwise counts stalled cycles.
        if (in[5])
            exp_stall = 32'd0;
        else if (ex[4])
            exp_stall = exp_stall + 32'd1;
        step_id++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [6:0] got;
            e   = sb.pop_front();
            got = {pc_enable, if_id_enable, id_nop, md_go, md_sel_div, md_busy, md_finish};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL outputs step=%0d got=%b want=%b", e.id, got, e.v);
            end
            total++;
            if (stall_cycles !== e.s) begin
                bad++;
                $display("FAIL stall_cycles step=%0d got=%0d want=%0d", e.id, stall_cycles, e.s);
            end
        end
    end

    initial begin
        {reset, hz_load_stall, md_start, md_is_div, hilo_read, md_cancel} = I_RST;

        // Reset, then idle state with all inputs low.
        step(I_RST, 1'b0, 7'b0);
        step(I_RST, 1'b0, 7'b0);
        step(I_NONE, 1'b1, 7'b1100000);

        // Mult issue: go at T0, busy T1..T4, finish T4, no stall.
        step(I_MUL, 1'b1, 7'b1101000);
        for (int i = 0; i < 3; i++) step(I_NONE, 1'b1, 7'b1100010);
        step(I_NONE, 1'b1, 7'b1100011);
        step(I_NONE, 1'b1, 7'b1100000);

        // Divide with MFHI from T3: stall T3..T16, finish T16, released T17.
        step(I_DIV, 1'b1, 7'b1101000);
        for (int i = 0; i < 2; i++) step(I_NONE, 1'b1, 7'b1100110);
        for (int i = 0; i < 13; i++) step(I_HR, 1'b1, 7'b0010110);
        step(I_HR, 1'b1, 7'b0010111);
        step(I_HR, 1'b1, 7'b1100100);
        step(I_NONE, 1'b1, 7'b1100100);

        // Load stall blocks issue, then mult accepted once it drops.
        step(I_LS | I_MUL, 1'b1, 7'b0010100);
        step(I_MUL, 1'b1, 7'b1101100);
        for (int i = 0; i < 3; i++) step(I_NONE, 1'b1, 7'b1100010);
        step(I_NONE, 1'b1, 7'b1100011);
        step(I_NONE, 1'b1, 7'b1100000);

        // Cancel in the finish cycle wins: no finish, idle next cycle.
        step(I_MUL, 1'b1, 7'b1101000);
        for (int i = 0; i < 3; i++) step(I_NONE, 1'b1, 7'b1100010);
        step(I_CN, 1'b1, 7'b1100010);
        step(I_NONE, 1'b1, 7'b1100000);
        step(I_NONE, 1'b1, 7'b1100000);

        // Back-to-back: second start held from T1, stalled T1..T4, go T5, finish T9.
        step(I_MUL, 1'b1, 7'b1101000);
        for (int i = 0; i < 3; i++) step(I_MUL, 1'b1, 7'b0010010);
        step(I_MUL, 1'b1, 7'b0010011);
        step(I_MUL, 1'b1, 7'b1101000);
        for (int i = 0; i < 3; i++) step(I_NONE, 1'b1, 7'b1100010);
        step(I_NONE, 1'b1, 7'b1100011);
        step(I_NONE, 1'b1, 7'b1100000);

        // Load stall coinciding with a busy MFLO read: one combined stall cycle.
        step(I_MUL, 1'b1, 7'b1101000);
        step(I_LS | I_HR, 1'b1, 7'b0010010);
        for (int i = 0; i < 2; i++) step(I_NONE, 1'b1, 7'b1100010);
        step(I_NONE, 1'b1, 7'b1100011);

        // Early cancel of a divide; cancel while idle has no effect.
        step(I_DIV, 1'b1, 7'b1101000);
        step(I_NONE, 1'b1, 7'b1100110);
        step(I_CN, 1'b1, 7'b1100110);
        step(I_CN, 1'b1, 7'b1100100);
        step(I_NONE, 1'b1, 7'b1100100);

        // Reset mid-divide: abandoned, never finishes, counter cleared.
        step(I_DIV, 1'b1, 7'b1101100);
        for (int i = 0; i < 4; i++) step(I_NONE, 1'b1, 7'b1100110);
        step(I_RST, 1'b1, 7'b1100110);
        step(I_HR, 1'b1, 7'b1100000);
        for (int i = 0; i < 14; i++) step(I_NONE, 1'b1, 7'b1100000);

        begin
            int waited = 0;
            while (sb.size() > 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            if (sb.size() > 0) begin
                total++;
                bad++;
                $display("FAIL drain pending=%0d want=0", sb.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
